// File: rtl/d_ff_stage.sv
// Single WIDTH-bit register with asynchronous active-high reset.
// Latency: 1 clk edge d->q. Backpressure: none, captures every rising edge.
module d_ff_stage #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_ff.sv
// Parameterised register chain: q is d delayed by STAGES rising clk edges.
// Latency: STAGES cycles. Backpressure: none, every edge shifts the chain.
module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STAGES      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "d_ff: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "d_ff: STAGES must be >= 1");
  end

  // chain[0] is the input tap; chain[STAGES] is the last register, driven straight to q.
  logic [WIDTH-1:0] chain [STAGES+1];

  assign chain[0] = d;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .d   (chain[i]),
      .q   (chain[i+1])
    );
  end

  assign q = chain[STAGES];

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: default 1-bit/1-stage instance and an 8-bit/3-stage instance,
// compared against a sample-history model of "q = d from STAGES edges ago".
module tb_d_ff;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       d_a;
  logic [7:0] d_b;
  logic       q_a;
  logic [7:0] q_b;

  always #5 clk = ~clk;

  d_ff u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .d   (d_a),
    .q   (q_a)
  );

  d_ff #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .STAGES      (3)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .d   (d_b),
    .q   (q_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Values captured since the last reset, newest at the back, at most STAGES kept.
  logic       hist_a [$];
  logic [7:0] hist_b [$];

  function automatic logic exp_a();
    return (hist_a.size() >= 1) ? hist_a[hist_a.size()-1] : 1'b0;
  endfunction

  function automatic logic [7:0] exp_b();
    return (hist_b.size() >= 3) ? hist_b[hist_b.size()-3] : 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst_a) hist_a.delete();
    else begin
      hist_a.push_back(d_a);
      if (hist_a.size() > 1) void'(hist_a.pop_front());
    end
    if (rst_b) hist_b.delete();
    else begin
      hist_b.push_back(d_b);
      if (hist_b.size() > 3) void'(hist_b.pop_front());
    end
  endtask

  task automatic edge_check(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_a"}, {7'b0, q_a}, {7'b0, exp_a()});
    chk({tag, "_b"}, q_b, exp_b());
  endtask

  task automatic step(input logic ra, input logic da, input logic rb, input logic [7:0] db,
                      input string tag);
    @(negedge clk);
    rst_a = ra;
    d_a   = da;
    rst_b = rb;
    d_b   = db;
    edge_check(tag);
  endtask

  // Raises both resets between edges and checks q reacts without a clock edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    model_edge();
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    hist_a.delete();
    hist_b.delete();
    #1;
    chk({tag, "_a"}, {7'b0, q_a}, 8'h00);
    chk({tag, "_b"}, q_b, 8'hA5);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    d_a   = 1'b0;
    d_b   = 8'h00;
    #1;
    chk("reset_async_a", {7'b0, q_a}, 8'h00);
    chk("reset_async_b", q_b, 8'hA5);

    // 1: reset held with d=0
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 8'h00, "t1_rst");
    chk("t1_q_a", {7'b0, q_a}, 8'h00);

    // 2: release, d low two cycles, then a single high cycle
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 8'h00, "t2_low");
    step(1'b0, 1'b1, 1'b0, 8'h00, "t2_rise");
    chk("t2_rise_lit", {7'b0, q_a}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 8'h00, "t2_fall");
    chk("t2_fall_lit", {7'b0, q_a}, 8'h00);

    // 3: d held high five cycles
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'hFF, "t3_hold");
      chk("t3_hold_lit", {7'b0, q_a}, 8'h01);
    end

    // 4: asynchronous reset with q=1, then held with d=1
    mid_reset("t4_async");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h77, "t4_hold");
      chk("t4_hold_lit", {7'b0, q_a}, 8'h00);
    end

    // 5: glitch on d between edges is not captured
    step(1'b0, 1'b0, 1'b0, 8'h00, "t5_pre");
    step(1'b0, 1'b0, 1'b0, 8'h00, "t5_pre");
    @(negedge clk);
    #2 d_a = 1'b1; d_b = 8'hFF;
    #2 d_a = 1'b0; d_b = 8'h00;
    edge_check("t5_glitch");
    chk("t5_glitch_lit", {7'b0, q_a}, 8'h00);

    // 6: 3-stage instance, single-cycle 8'h3C appears exactly 3 edges later
    mid_reset("t6_rst");
    step(1'b1, 1'b0, 1'b1, 8'h00, "t6_rst_hold");
    step(1'b0, 1'b0, 1'b0, 8'h3C, "t6_load");
    chk("t6_e1_lit", q_b, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'h11, "t6_e2");
    chk("t6_e2_lit", q_b, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'h22, "t6_e3");
    chk("t6_e3_lit", q_b, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 8'h33, "t6_e4");
    chk("t6_e4_lit", q_b, 8'h11);
    step(1'b0, 1'b0, 1'b0, 8'h44, "t6_e5");
    chk("t6_e5_lit", q_b, 8'h22);

    // Randomised traffic with sporadic synchronous-looking and mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        mid_reset("rnd_async");
      end else begin
        step(($urandom_range(0, 15) == 0), 1'($urandom),
             ($urandom_range(0, 15) == 0), 8'($urandom), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
